// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, jump flush,
// decode bypass and EX forward select, with perf counters.
module pipeline_hazard_ctrl (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        fd_valid,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic        fd_use_rs1,
  input  logic        fd_use_rs2,
  input  logic [4:0]  fd_write_reg,
  input  logic        fd_reg_wrenable,
  input  logic        fd_mem_to_reg,
  input  logic        fd_is_jump,
  output logic        stall_fd,
  output logic        bubble_ex,
  output logic        flush_fd,
  output logic        dec_byp_a,
  output logic        dec_byp_b,
  output logic        ex_fwd_a,
  output logic        ex_fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] retire_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] wr;
    logic       we;
    logic       m2r;
    logic       jmp;
  } slot_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  logic        fwd_a_q, fwd_a_d;
  logic        fwd_b_q, fwd_b_d;
  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;

  logic ex_rd1, ex_rd2, mem_rd1, mem_rd2;
  logic load_use, jump_ex;

  function automatic logic writes(
    input slot_t      s,
    input logic [4:0] r
  );
    return s.valid & s.we & (s.wr == r) & (r != 5'd0);
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] c,
    input logic        en
  );
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  // Hazard detection and pipeline-control outputs
  always_comb begin
    ex_rd1    = writes(ex_q, fd_rs1) & fd_use_rs1;
    ex_rd2    = writes(ex_q, fd_rs2) & fd_use_rs2;
    mem_rd1   = writes(mem_q, fd_rs1) & fd_use_rs1;
    mem_rd2   = writes(mem_q, fd_rs2) & fd_use_rs2;
    jump_ex   = ex_q.valid & ex_q.jmp;
    load_use  = fd_valid & ex_q.m2r & (ex_rd1 | ex_rd2);
    stall_fd  = 1'b0;
    bubble_ex = 1'b0;
    flush_fd  = 1'b0;
    priority case (1'b1)
      jump_ex: begin
        flush_fd  = 1'b1;
        bubble_ex = 1'b1;
      end
      load_use: begin
        stall_fd  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
    dec_byp_a = fd_valid & mem_rd1;
    dec_byp_b = fd_valid & mem_rd2;
  end

  // Slot advance, forward select and FSM next state
  always_comb begin
    mem_d   = ex_q;
    ex_d    = '0;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (!bubble_ex) begin
      ex_d.valid = fd_valid;
      ex_d.wr    = fd_write_reg;
      ex_d.we    = fd_reg_wrenable;
      ex_d.m2r   = fd_mem_to_reg;
      ex_d.jmp   = fd_is_jump;
      fwd_a_d    = ex_rd1 & ~ex_q.m2r;
      fwd_b_d    = ex_rd2 & ~ex_q.m2r;
    end
    state_d = RUN;
    priority case (1'b1)
      (state_q == ILLEGAL): state_d = RUN;
      jump_ex:              state_d = FLUSH;
      load_use:             state_d = LDSTALL;
      default:              state_d = RUN;
    endcase
    stall_cnt_d  = sat_inc(stall_cnt_q, stall_fd);
    flush_cnt_d  = sat_inc(flush_cnt_q, flush_fd);
    retire_cnt_d = sat_inc(retire_cnt_q, mem_q.valid);
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      state_q      <= RUN;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign ex_fwd_a   = fwd_a_q;
  assign ex_fwd_b   = fwd_b_q;
  assign state      = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule
